// File: rtl/hsv_pkg.sv
// Shared types, constants and the exact divide-by-255 helper for the HSV->RGB path.
package hsv_pkg;

    typedef struct packed {
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } hsv_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [2:0] sector_t;

    localparam int unsigned HUE_MAX    = 359;
    localparam int unsigned HUE_WRAP   = 360;
    localparam int unsigned SECTOR_DEG = 60;

    // floor(x/255) without a divider; exact for 0..65025 (255*255).
    function automatic logic [7:0] div255(input logic [15:0] x);
        logic [16:0] y;
        logic [16:0] z;
        y = {1'b0, x} + 17'd1;
        z = y + (y >> 8);
        return 8'(z >> 8);
    endfunction

endpackage

// File: rtl/hsv_sector_split.sv
// Combinational hue folding: wraps out-of-range hue once, then splits into 60-degree sector and offset.
module hsv_sector_split
    import hsv_pkg::*;
(
    input  logic [8:0] h,
    output logic [8:0] h_wrap,
    output sector_t    sector,
    output logic [5:0] f
);

    logic [8:0] base;

    always_comb begin
        h_wrap = (h > 9'(HUE_MAX)) ? h - 9'(HUE_WRAP) : h;
        sector = 3'd0;
        base   = 9'd0;
        // Compare chain instead of a divider; h_wrap <= 359 after one fold since h <= 511.
        if (h_wrap >= 9'(5 * SECTOR_DEG)) begin
            sector = 3'd5;
            base   = 9'(5 * SECTOR_DEG);
        end else if (h_wrap >= 9'(4 * SECTOR_DEG)) begin
            sector = 3'd4;
            base   = 9'(4 * SECTOR_DEG);
        end else if (h_wrap >= 9'(3 * SECTOR_DEG)) begin
            sector = 3'd3;
            base   = 9'(3 * SECTOR_DEG);
        end else if (h_wrap >= 9'(2 * SECTOR_DEG)) begin
            sector = 3'd2;
            base   = 9'(2 * SECTOR_DEG);
        end else if (h_wrap >= 9'(SECTOR_DEG)) begin
            sector = 3'd1;
            base   = 9'(SECTOR_DEG);
        end
        f = 6'(h_wrap - base);
    end

endmodule

// File: rtl/hsv_to_rgb_pipe.sv
// Three-stage streaming HSV->RGB converter with valid/ready and pass-through sideband.
// Optional out-of-range hue counter enabled by defining HSV2RGB_OOR_CNT_EN.
module hsv_to_rgb_pipe
    import hsv_pkg::*;
#(
    parameter int SIDEBAND_W = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8:0]            in_h,
    input  logic [7:0]            in_s,
    input  logic [7:0]            in_v,
    input  logic [SIDEBAND_W-1:0] in_side,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_r,
    output logic [7:0]            out_g,
    output logic [7:0]            out_b,
    output logic [SIDEBAND_W-1:0] out_side,
    output logic [CNT_W-1:0]      hue_oor_cnt
);

    hsv_t       in_pix;
    logic       stall;
    logic       adv;
    logic [8:0] h_wrap;
    sector_t    split_sector;
    logic [5:0] split_f;

    assign in_pix   = '{h: in_h, s: in_s, v: in_v};
    // Whole pipe moves or holds together; bubbles flow whenever the output is not blocked.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign adv      = !stall;

    hsv_sector_split u_split (
        .h      (in_pix.h),
        .h_wrap (h_wrap),
        .sector (split_sector),
        .f      (split_f)
    );

    logic                  s1_valid_reg;
    sector_t               s1_sector_reg;
    logic [5:0]            s1_f_reg;
    logic [7:0]            s1_s_reg;
    logic [7:0]            s1_v_reg;
    logic [SIDEBAND_W-1:0] s1_side_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sector_reg <= '0;
            s1_f_reg      <= '0;
            s1_s_reg      <= '0;
            s1_v_reg      <= '0;
            s1_side_reg   <= '0;
        end else if (adv) begin
            s1_valid_reg  <= in_valid;
            s1_sector_reg <= split_sector;
            s1_f_reg      <= split_f;
            s1_s_reg      <= in_pix.s;
            s1_v_reg      <= in_pix.v;
            s1_side_reg   <= in_side;
        end
    end

    logic [15:0] prod_a;
    logic [15:0] prod_b;
    logic [7:0]  a_val;
    logic [7:0]  b_val;
    logic [7:0]  p_next;
    logic [7:0]  q_next;
    logic [7:0]  t_next;

    always_comb begin
        prod_a = 16'(s1_s_reg) * 16'(s1_f_reg);
        prod_b = 16'(s1_s_reg) * (16'(SECTOR_DEG) - 16'(s1_f_reg));
        a_val  = 8'(prod_a / 16'(SECTOR_DEG));
        b_val  = 8'(prod_b / 16'(SECTOR_DEG));
        p_next = div255(16'(s1_v_reg) * 16'(8'd255 - s1_s_reg));
        q_next = div255(16'(s1_v_reg) * 16'(8'd255 - a_val));
        t_next = div255(16'(s1_v_reg) * 16'(8'd255 - b_val));
    end

    logic                  s2_valid_reg;
    sector_t               s2_sector_reg;
    logic [7:0]            s2_v_reg;
    logic [7:0]            s2_p_reg;
    logic [7:0]            s2_q_reg;
    logic [7:0]            s2_t_reg;
    logic [SIDEBAND_W-1:0] s2_side_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_sector_reg <= '0;
            s2_v_reg      <= '0;
            s2_p_reg      <= '0;
            s2_q_reg      <= '0;
            s2_t_reg      <= '0;
            s2_side_reg   <= '0;
        end else if (adv) begin
            s2_valid_reg  <= s1_valid_reg;
            s2_sector_reg <= s1_sector_reg;
            s2_v_reg      <= s1_v_reg;
            s2_p_reg      <= p_next;
            s2_q_reg      <= q_next;
            s2_t_reg      <= t_next;
            s2_side_reg   <= s1_side_reg;
        end
    end

    rgb_t rgb_next;

    always_comb begin
        rgb_next = '{r: s2_v_reg, g: s2_t_reg, b: s2_p_reg};
        case (s2_sector_reg)
            3'd1:    rgb_next = '{r: s2_q_reg, g: s2_v_reg, b: s2_p_reg};
            3'd2:    rgb_next = '{r: s2_p_reg, g: s2_v_reg, b: s2_t_reg};
            3'd3:    rgb_next = '{r: s2_p_reg, g: s2_q_reg, b: s2_v_reg};
            3'd4:    rgb_next = '{r: s2_t_reg, g: s2_p_reg, b: s2_v_reg};
            3'd5:    rgb_next = '{r: s2_v_reg, g: s2_p_reg, b: s2_q_reg};
            default: rgb_next = '{r: s2_v_reg, g: s2_t_reg, b: s2_p_reg};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_side  <= '0;
        end else if (adv) begin
            out_valid <= s2_valid_reg;
            out_r     <= rgb_next.r;
            out_g     <= rgb_next.g;
            out_b     <= rgb_next.b;
            out_side  <= s2_side_reg;
        end
    end

`ifdef HSV2RGB_OOR_CNT_EN
    logic [CNT_W-1:0] oor_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oor_cnt_reg <= '0;
        end else if (in_valid && in_ready && (in_h > 9'(HUE_MAX)) && (oor_cnt_reg != '1)) begin
            oor_cnt_reg <= oor_cnt_reg + CNT_W'(1);
        end
    end

    assign hue_oor_cnt = oor_cnt_reg;
`else
    assign hue_oor_cnt = '0;
`endif

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// Scoreboard bench for hsv_to_rgb_pipe: directed vectors, stall/reset cases, random sweep.
module tb_hsv_to_rgb_pipe;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] side;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_h;
    logic [7:0]  in_s;
    logic [7:0]  in_v;
    logic [1:0]  in_side;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;
    logic [1:0]  out_side;
    logic [15:0] hue_oor_cnt;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_oor  = 0;
    bit   drv_done;

    hsv_to_rgb_pipe #(.SIDEBAND_W(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_h        (in_h),
        .in_s        (in_s),
        .in_v        (in_v),
        .in_side     (in_side),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .out_side    (out_side),
        .hue_oor_cnt (hue_oor_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input int h, input int s, input int v, input logic [1:0] side);
        int   hp, sec, f, a, b, p, q, t;
        exp_t e;
        hp  = (h > 359) ? h - 360 : h;
        sec = hp / 60;
        f   = hp - 60 * sec;
        a   = (s * f) / 60;
        b   = (s * (60 - f)) / 60;
        p   = (v * (255 - s)) / 255;
        q   = (v * (255 - a)) / 255;
        t   = (v * (255 - b)) / 255;
        case (sec)
            0:       e = '{8'(v), 8'(t), 8'(p), side};
            1:       e = '{8'(q), 8'(v), 8'(p), side};
            2:       e = '{8'(p), 8'(v), 8'(t), side};
            3:       e = '{8'(p), 8'(q), 8'(v), side};
            4:       e = '{8'(t), 8'(p), 8'(v), side};
            default: e = '{8'(v), 8'(p), 8'(q), side};
        endcase
        return e;
    endfunction

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int h, input int s, input int v, input logic [1:0] side, input exp_t e);
        bit acc;
        acc      = 1'b0;
        in_h     = 9'(h);
        in_s     = 8'(s);
        in_v     = 8'(v);
        in_side  = side;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                expq.push_back(e);
                if (h > 359) exp_oor++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
        check("drain_empty", expq.size(), 32'd0);
    endtask

    // Monitor: samples 2 time units after each negedge, after bench inputs have settled.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", {6'd0, out_r, out_g, out_b, out_side}, 32'd0);
                    n_fail += (out_r == 0 && out_g == 0 && out_b == 0 && out_side == 0) ? 1 : 0;
                end else begin
                    e = expq.pop_front();
                    check("pixel", {6'd0, out_r, out_g, out_b, out_side}, {6'd0, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_h      = '0;
        in_s      = '0;
        in_v      = '0;
        in_side   = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        check("rst_side", {30'd0, out_side}, 32'd0);
        check("rst_cnt", {16'd0, hue_oor_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: out_valid rises in the third cycle after acceptance.
        send(0, 255, 255, 2'b01, '{8'd255, 8'd0, 8'd0, 2'b01});
        check("lat_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_c2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_c3", {31'd0, out_valid}, 32'd1);
        drain();

        send(120, 255, 255, 2'b00, '{8'd0,   8'd255, 8'd0,   2'b00});
        send(240, 255, 255, 2'b10, '{8'd0,   8'd0,   8'd255, 2'b10});
        send(30,  255, 200, 2'b11, '{8'd200, 8'd100, 8'd0,   2'b11});
        send(250, 0,   77,  2'b01, '{8'd77,  8'd77,  8'd77,  2'b01});
        send(300, 255, 0,   2'b00, '{8'd0,   8'd0,   8'd0,   2'b00});
        drain();

        check("oor_before", {16'd0, hue_oor_cnt}, 32'd0);
        send(400, 255, 255, 2'b00, '{8'd255, 8'd170, 8'd0, 2'b00});
`ifdef HSV2RGB_OOR_CNT_EN
        check("oor_after", {16'd0, hue_oor_cnt}, 32'd1);
`else
        check("oor_after", {16'd0, hue_oor_cnt}, 32'd0);
`endif
        drain();

        // Eight-pixel stream with a 4-cycle downstream stall in the middle.
        fork
            begin
                send(0,   255, 255, 2'b01, '{8'd255, 8'd0,   8'd0,   2'b01});
                send(60,  255, 255, 2'b00, '{8'd255, 8'd255, 8'd0,   2'b00});
                send(120, 255, 255, 2'b00, '{8'd0,   8'd255, 8'd0,   2'b00});
                send(240, 255, 255, 2'b00, '{8'd0,   8'd0,   8'd255, 2'b00});
                send(30,  255, 200, 2'b00, '{8'd200, 8'd100, 8'd0,   2'b00});
                send(250, 0,   77,  2'b00, '{8'd77,  8'd77,  8'd77,  2'b00});
                send(300, 255, 0,   2'b00, '{8'd0,   8'd0,   8'd0,   2'b00});
                send(400, 255, 255, 2'b10, '{8'd255, 8'd170, 8'd0,   2'b10});
            end
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with pixels in flight: everything dropped, nothing emerges afterwards.
        send(0,   255, 255, 2'b01, '{8'd255, 8'd0,   8'd0, 2'b01});
        send(120, 255, 255, 2'b00, '{8'd0,   8'd255, 8'd0, 2'b00});
        send(400, 255, 255, 2'b10, '{8'd255, 8'd170, 8'd0, 2'b10});
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        expq.delete();
        exp_oor = 0;
        repeat (2) @(negedge clk);
        check("rst_mid_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        check("rst_mid_cnt", {16'd0, hue_oor_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);

        // Random sweep with random downstream backpressure.
        drv_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    int h, s, v;
                    logic [1:0] sd;
                    h  = $urandom_range(0, 511);
                    s  = $urandom_range(0, 255);
                    v  = $urandom_range(0, 255);
                    sd = 2'($urandom_range(0, 3));
                    send(h, s, v, sd, model(h, s, v, sd));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
`ifdef HSV2RGB_OOR_CNT_EN
        check("oor_final", {16'd0, hue_oor_cnt}, 32'(exp_oor));
`else
        check("oor_final", {16'd0, hue_oor_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
